// File: rtl/add_seq_pkg.sv
// Shared encodings for the sequential digit-serial adder: FSM states and op-mode constants.
package add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/add_dbit.sv
// Combinational W-bit ripple-carry adder used as the per-cycle digit datapath.
module add_dbit #(
  parameter int W = 4
) (
  input  logic         ci,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] r,
  output logic         co
);

  logic [W:0] c;

  // NOTE: blocking assignments here are deliberate; each carry feeds the next bit within the same evaluation.
  always_comb begin
    c[0] = ci;
    for (int i = 0; i < W; i++) begin
      r[i]     = x[i] ^ y[i] ^ c[i];
      c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign co = c[W];

endmodule

// File: rtl/add_seq_nbit.sv
// Digit-serial N-bit adder/subtractor: one D-bit digit per cycle, 4-phase req/ack handshake.
module add_seq_nbit #(
  parameter int N = 8,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req,
  input  logic         op,
  input  logic         ci,
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  output logic         ack,
  output logic [N-1:0] r,
  output logic         co,
  output logic         ovf
);
  import add_seq_pkg::*;

  localparam int NDIG = N / D;
  localparam int CW   = $clog2(NDIG + 1);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (D < 1 || D > N || (N % D) != 0) begin : g_bad_params
    $error("add_seq_nbit: N must be a positive multiple of D");
  end

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    xs, ys;
  logic            carry;
  logic            x_msb, y_msb;
  logic [N-1:0]    y_eff;
  logic [D-1:0]    dsum;
  logic            dco;
  logic            last_digit;
  logic [N-1:0]    r_shift;

  assign y_eff      = (op == OP_SUB) ? ~y : y;
  assign last_digit = (cnt == LAST);
  // New digit enters at the top of r so the full result lands in place after NDIG shifts.
  assign r_shift    = (r >> D) | (N'(dsum) << (N - D));

  add_dbit #(.W(D)) u_digit (
    .ci (carry),
    .x  (xs[D-1:0]),
    .y  (ys[D-1:0]),
    .r  (dsum),
    .co (dco)
  );

  // NOTE: next-state is defaulted to the current state first so no path through this block infers a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req)        state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    if (!req)       state_next = IDLE;
      default:                 state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      xs    <= '0;
      ys    <= '0;
      carry <= 1'b0;
      x_msb <= 1'b0;
      y_msb <= 1'b0;
      ack   <= 1'b0;
      r     <= '0;
      co    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (req) begin
          xs    <= x;
          ys    <= y_eff;
          carry <= (op == OP_SUB) ? 1'b1 : ci;
          x_msb <= x[N-1];
          y_msb <= y_eff[N-1];
          cnt   <= '0;
        end
        RUN: begin
          r     <= r_shift;
          carry <= dco;
          xs    <= xs >> D;
          ys    <= ys >> D;
          cnt   <= cnt + 1'b1;
          if (last_digit) begin
            ack <= 1'b1;
            co  <= dco;
            // Operand MSBs were captured at start because the operand registers have shifted away.
            ovf <= (x_msb == y_msb) && (dsum[D-1] != x_msb);
          end
        end
        DONE: if (!req) ack <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_nbit.sv
// Directed bench for add_seq_nbit: four instances (D=4,1,2,8 with N=8) share one stimulus bus.
module tb_add_seq_nbit;

  logic       clk = 1'b0;
  logic       rst, req, op, ci;
  logic [7:0] x, y;

  // Instance index: 0 -> D=4 (primary), 1 -> D=1, 2 -> D=2, 3 -> D=8
  logic [3:0]      ack_a, co_a, ovf_a;
  logic [3:0][7:0] r_a;
  int lat_exp [4] = '{2, 8, 4, 1};

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_seq_nbit #(.N(8), .D(4)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .ci(ci), .x(x), .y(y),
    .ack(ack_a[0]), .r(r_a[0]), .co(co_a[0]), .ovf(ovf_a[0])
  );
  add_seq_nbit #(.N(8), .D(1)) u_d1 (
    .clk(clk), .rst(rst), .req(req), .op(op), .ci(ci), .x(x), .y(y),
    .ack(ack_a[1]), .r(r_a[1]), .co(co_a[1]), .ovf(ovf_a[1])
  );
  add_seq_nbit #(.N(8), .D(2)) u_d2 (
    .clk(clk), .rst(rst), .req(req), .op(op), .ci(ci), .x(x), .y(y),
    .ack(ack_a[2]), .r(r_a[2]), .co(co_a[2]), .ovf(ovf_a[2])
  );
  add_seq_nbit #(.N(8), .D(8)) u_d8 (
    .clk(clk), .rst(rst), .req(req), .op(op), .ci(ci), .x(x), .y(y),
    .ack(ack_a[3]), .r(r_a[3]), .co(co_a[3]), .ovf(ovf_a[3])
  );

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; op = 1'b0; ci = 1'b0; x = 8'h00; y = 8'h00;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ack_a[i], r_a[i], co_a[i], ovf_a[i]} !== 11'd0) begin
        failures++;
        $display("FAIL reset[%0d] got ack=%b r=%h co=%b ovf=%b exp all 0",
                 i, ack_a[i], r_a[i], co_a[i], ovf_a[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // One full handshake on all instances; checks latency, result, flags and ack release.
  task automatic run_op(input string name, input logic op_i, input logic [7:0] x_i,
                        input logic [7:0] y_i, input logic ci_i, input logic [7:0] er,
                        input logic eco, input logic eovf);
    int lat [4];
    lat = '{0, 0, 0, 0};
    op = op_i; x = x_i; y = y_i; ci = ci_i; req = 1'b1;
    @(negedge clk);
    for (int cyc = 1; cyc <= 20 && (lat[0] == 0 || lat[1] == 0 || lat[2] == 0 || lat[3] == 0); cyc++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++)
        if (ack_a[i] === 1'b1 && lat[i] == 0) lat[i] = cyc;
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (lat[i] != lat_exp[i]) begin
        failures++;
        $display("FAIL %s[%0d] latency got=%0d exp=%0d", name, i, lat[i], lat_exp[i]);
      end
      checks++;
      if ({ack_a[i], r_a[i], co_a[i], ovf_a[i]} !== {1'b1, er, eco, eovf}) begin
        failures++;
        $display("FAIL %s[%0d] got ack=%b r=%h co=%b ovf=%b exp ack=1 r=%h co=%b ovf=%b",
                 name, i, ack_a[i], r_a[i], co_a[i], ovf_a[i], er, eco, eovf);
      end
    end
    req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ack_a[i], r_a[i], co_a[i], ovf_a[i]} !== {1'b0, er, eco, eovf}) begin
        failures++;
        $display("FAIL %s_release[%0d] got ack=%b r=%h co=%b ovf=%b exp ack=0 r=%h co=%b ovf=%b",
                 name, i, ack_a[i], r_a[i], co_a[i], ovf_a[i], er, eco, eovf);
      end
    end
  endtask

  task automatic test_arith();
    run_op("add_basic", 1'b0, 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    run_op("add_carry", 1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_ovf",   1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("add_ci",    1'b0, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0);
    run_op("sub_neg",   1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
    run_op("sub_ovf",   1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
    run_op("sub_ci_ig", 1'b1, 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
  endtask

  // req dropped and x changed right after the sampling edge: result still uses latched x.
  task automatic test_req_drop();
    op = 1'b0; ci = 1'b0; x = 8'h3C; y = 8'h0F; req = 1'b1;
    @(negedge clk);
    x = 8'h00; req = 1'b0;
    @(negedge clk);
    checks++;
    if (ack_a[0] !== 1'b0) begin
      failures++;
      $display("FAIL req_drop_early ack got=%b exp=0", ack_a[0]);
    end
    @(negedge clk);
    checks++;
    if ({ack_a[0], r_a[0]} !== {1'b1, 8'h4B}) begin
      failures++;
      $display("FAIL req_drop_ack got ack=%b r=%h exp ack=1 r=4b", ack_a[0], r_a[0]);
    end
    @(negedge clk);
    checks++;
    if ({ack_a[0], r_a[0]} !== {1'b0, 8'h4B}) begin
      failures++;
      $display("FAIL req_drop_one_cycle got ack=%b r=%h exp ack=0 r=4b", ack_a[0], r_a[0]);
    end
    repeat (10) @(negedge clk);
  endtask

  // req held high in DONE: outputs frozen, new operands ignored until req cycles low.
  task automatic test_hold();
    op = 1'b0; ci = 1'b0; x = 8'h3C; y = 8'h0F; req = 1'b1;
    repeat (3) @(negedge clk);
    x = 8'hFF; y = 8'hFF; ci = 1'b1;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ack_a[i], r_a[i]} !== {1'b1, 8'h4B}) begin
        failures++;
        $display("FAIL hold[%0d] got ack=%b r=%h exp ack=1 r=4b", i, ack_a[i], r_a[i]);
      end
    end
    req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ack_a, r_a[0]} !== {4'b0000, 8'h4B}) begin
      failures++;
      $display("FAIL hold_release got ack=%b r=%h exp ack=0000 r=4b", ack_a, r_a[0]);
    end
  endtask

  task automatic test_rst_mid();
    op = 1'b0; ci = 1'b0; x = 8'h3C; y = 8'h0F; req = 1'b1;
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({ack_a[i], r_a[i], co_a[i], ovf_a[i]} !== 11'd0) begin
        failures++;
        $display("FAIL rst_mid[%0d] got ack=%b r=%h co=%b ovf=%b exp all 0",
                 i, ack_a[i], r_a[i], co_a[i], ovf_a[i]);
      end
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (ack_a !== 4'b0000) begin
        failures++;
        $display("FAIL rst_mid_no_ack got ack=%b exp=0000", ack_a);
      end
    end
    run_op("after_rst", 1'b0, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
  endtask

  // rst and req together: reset wins, so no operation may start.
  task automatic test_rst_priority();
    op = 1'b0; ci = 1'b0; x = 8'h11; y = 8'h22; req = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (ack_a !== 4'b0000) begin
        failures++;
        $display("FAIL rst_priority got ack=%b exp=0000", ack_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_req_drop();
    test_hold();
    test_rst_mid();
    test_rst_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
